// File: rtl/div_seq_ctrl.sv
// ---------------------------------------------------------------------------
// div_seq_ctrl
//   Sequencer for the MIPS divider datapath. It performs an iterative
//   restoring divide and produces one quotient bit per clock. Each step
//   shifts the next dividend bit into the partial remainder, compares the
//   result against the divisor with a cascaded 4-bit compare chain
//   (A>=B = AGB | AEB), subtracts when the compare succeeds, and shifts the
//   compare result into the quotient. The block sits between ID/EX DIV/DIVU
//   issue and the HI/LO registers.
//
// Optional feature macro: DIV_SIGNED_EN
//   When the macro is defined, the Signed port exists. Signed operations
//   divide the operand magnitudes. A one-cycle FIX state then applies the
//   result signs. When the macro is undefined, the block is unsigned only.
//
// Parameters
//   WIDTH  operand / quotient / remainder width (>=4, multiple of 4)
//   CNT_W  iteration counter width, >= clog2(WIDTH)+1
//
// Ports
//   CLK        in   single clock, rising edge
//   RSTn       in   asynchronous active-low reset
//   Start      in   request, sampled only in IDLE
//   Abort      in   synchronous cancel, any state -> IDLE, no Done
//   Dividend   in   captured on an accepted Start
//   Divisor    in   captured on an accepted Start
//   Signed     in   (DIV_SIGNED_EN only) captured on an accepted Start
//   Busy       out  high while iterating (RUN, FIX)
//   Done       out  one-cycle pulse, results valid
//   DivByZero  out  valid with Done, held until the next accepted Start
//   Quotient   out  result, held until the next completion
//   Remainder  out  result, held until the next completion
// ---------------------------------------------------------------------------
module div_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Start,
  input  logic             Abort,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
`ifdef DIV_SIGNED_EN
  input  logic             Signed,
`endif
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
`ifdef DIV_SIGNED_EN
    S_FIX,
`endif
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   r_q, r_d;        // partial remainder
  logic [WIDTH-1:0]   q_q, q_d;        // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0]   d_q, d_d;        // divisor (magnitude)
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
  logic               sgn_q, sgn_d;    // current op is signed, so FIX is needed
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
`endif

  // Cascaded magnitude compare built from 4-bit slices, from LSB to MSB.
  // A higher slice that is strictly greater or smaller decides the result.
  // An equal slice passes the lower result through.
  function automatic logic cmp_ge(input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b);
    logic       agb;
    logic       aeb;
    logic [3:0] as;
    logic [3:0] bs;
    agb = 1'b0;
    aeb = 1'b1;
    for (int i = 0; i < WIDTH / 4; i++) begin
      as  = a[4*i +: 4];
      bs  = b[4*i +: 4];
      agb = (as > bs) | ((as == bs) & agb);
      aeb = (as == bs) & aeb;
    end
    return agb | aeb;
  endfunction

  // One restoring step. T carries R's MSB as bit WIDTH. When that bit is
  // set, T exceeds any divisor. The WIDTH-bit difference is exact because
  // the true remainder is always below the divisor.
  logic [WIDTH:0]   t;
  logic             ge;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    t      = {r_q, q_q[WIDTH-1]};
    ge     = t[WIDTH] | cmp_ge(t[WIDTH-1:0], d_q);
    r_step = ge ? (t[WIDTH-1:0] - d_q) : t[WIDTH-1:0];
    q_step = {q_q[WIDTH-2:0], ge};
  end

  always_comb begin
    a_mag = Dividend;
    b_mag = Divisor;
`ifdef DIV_SIGNED_EN
    if (Signed) begin
      // The most negative value negates to itself. Read as unsigned, that
      // value is exactly its magnitude.
      if (Dividend[WIDTH-1]) a_mag = -Dividend;
      if (Divisor[WIDTH-1])  b_mag = -Divisor;
    end
`endif
  end

  // NOTE: every variable gets its hold value first. This keeps any path
  // through the case from leaving a signal unassigned, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    sgn_d      = sgn_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (Start && !Abort) begin
          dbz_d = 1'b0;
          if (Divisor == '0) begin
            // Divide by zero completes at once. Signed ops skip FIX.
            state_d = S_DONE;
            quot_d  = '1;
            rem_d   = Dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            r_d     = '0;
            q_d     = a_mag;
            d_d     = b_mag;
            cnt_d   = CNT_W'(WIDTH);
`ifdef DIV_SIGNED_EN
            sgn_d      = Signed;
            neg_quot_d = Signed & (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
            neg_rem_d  = Signed & Dividend[WIDTH-1];
`endif
          end
        end
      end

      S_RUN: begin
        if (Abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          r_d   = r_step;
          q_d   = q_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
`ifdef DIV_SIGNED_EN
            if (sgn_q) begin
              state_d = S_FIX;
            end else begin
              state_d = S_DONE;
              quot_d  = q_step;
              rem_d   = r_step;
            end
`else
            state_d = S_DONE;
            quot_d  = q_step;
            rem_d   = r_step;
`endif
          end
        end
      end

`ifdef DIV_SIGNED_EN
      S_FIX: begin
        state_d = S_IDLE;
        if (!Abort) begin
          state_d = S_DONE;
          quot_d  = neg_quot_q ? -q_q : q_q;
          rem_d   = neg_rem_q  ? -r_q : r_q;
        end
      end
`endif

      S_DONE: begin
        // Start is not queued here. The FSM always returns to IDLE.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments. All flops then
  // sample values from before the edge, whatever the statement order.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      sgn_q      <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
      sgn_q      <= sgn_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

`ifdef DIV_SIGNED_EN
  assign Busy = (state_q == S_RUN) || (state_q == S_FIX);
`else
  assign Busy = (state_q == S_RUN);
`endif
  assign Done      = (state_q == S_DONE);
  assign DivByZero = dbz_q;
  assign Quotient  = quot_q;
  assign Remainder = rem_q;

endmodule
